// File: rtl/cmul_round_axis_pkg.sv
// Shared definitions for the cmul_round_axis complex multiplier:
// sc-format field extraction, rounding-mode codes and counter sizing.
`ifndef CMUL_ROUND_AXIS_FIELDS
`define CMUL_ROUND_AXIS_FIELDS
`define CMUL_FIELD_I(d, w) d[2*(w)-1:(w)]
`define CMUL_FIELD_Q(d, w) d[(w)-1:0]
`endif

package cmul_round_axis_pkg;
    localparam int RND_TRUNC     = 0;
    localparam int RND_HALF_UP   = 1;
    localparam int SAT_CNT_WIDTH = 16;
endpackage

// File: rtl/cmul_round_sat.sv
// Combinational round, arithmetic shift and saturate for one signed component.
// Flags sat when the shifted value falls outside the output range.
module cmul_round_sat
    import cmul_round_axis_pkg::*;
#(
    parameter int WIDTH_IN  = 33,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = 15,
    parameter int ROUND     = RND_HALF_UP
) (
    input  logic signed [WIDTH_IN-1:0]  din,
    output logic        [WIDTH_OUT-1:0] dout,
    output logic                        sat
);
    // Work width covers the rounding carry and shifts past the input width.
    localparam int XW0 = ((WIDTH_IN > SHIFT) ? WIDTH_IN : SHIFT) + 2;
    localparam int XW  = (XW0 > WIDTH_OUT + 1) ? XW0 : WIDTH_OUT + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [XW-1:0] ONE_V   = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] RND_ADD =
        (ROUND == RND_HALF_UP && SHIFT > 0) ? (ONE_V << RSH) : '0;
    localparam logic signed [XW-1:0] MAX_V =
        {{(XW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V =
        {{(XW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

    logic signed [XW-1:0] ext_v;
    logic signed [XW-1:0] rnd_v;
    logic signed [XW-1:0] shf_v;

    always_comb begin
        ext_v = {{(XW-WIDTH_IN){din[WIDTH_IN-1]}}, din};
        rnd_v = ext_v + RND_ADD;
        shf_v = rnd_v >>> SHIFT;
        sat   = 1'b0;
        dout  = shf_v[WIDTH_OUT-1:0];
        if (shf_v > MAX_V) begin
            sat  = 1'b1;
            dout = MAX_V[WIDTH_OUT-1:0];
        end else if (shf_v < MIN_V) begin
            sat  = 1'b1;
            dout = MIN_V[WIDTH_OUT-1:0];
        end
    end
endmodule

// File: rtl/cmul_round_axis.sv
// Four-stage AXI-Stream complex multiplier (a*b or a*conj(b)) with rounding,
// saturation, per-beat saturation flags and a sticky saturation event counter.
module cmul_round_axis
    import cmul_round_axis_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = WIDTH_IN - 1,
    parameter int ROUND     = RND_HALF_UP,
    parameter int CNT_WIDTH = SAT_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*WIDTH_IN-1:0]  a_tdata,
    input  logic                   a_tlast,
    input  logic                   a_tvalid,
    output logic                   a_tready,
    input  logic [2*WIDTH_IN-1:0]  b_tdata,
    input  logic                   b_tlast,
    input  logic                   b_tvalid,
    output logic                   b_tready,
    input  logic                   conj_b,
    output logic [2*WIDTH_OUT-1:0] o_tdata,
    output logic                   o_tlast,
    output logic [1:0]             o_tuser,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [CNT_WIDTH-1:0]   sat_count,
    input  logic                   sat_clear
);
    localparam int PW = 2 * WIDTH_IN;
    localparam int SW = PW + 1;

    logic                   s1_valid_q, s1_valid_d, s1_conj_q, s1_conj_d, s1_last_q, s1_last_d;
    logic [PW-1:0]          s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                   s2_valid_q, s2_valid_d, s2_conj_q, s2_conj_d, s2_last_q, s2_last_d;
    logic signed [PW-1:0]   s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d, s2_ir_q, s2_ir_d, s2_ri_q, s2_ri_d;
    logic                   s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic signed [SW-1:0]   s3_re_q, s3_re_d, s3_im_q, s3_im_d;
    logic                   o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
    logic [2*WIDTH_OUT-1:0] o_tdata_q, o_tdata_d;
    logic [1:0]             o_tuser_q, o_tuser_d;
    logic [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;

    logic s1_ready, s2_ready, s3_ready, s4_ready, accept, sat_inc;
    logic signed [WIDTH_IN-1:0] ar, ai, br, bi;
    logic [WIDTH_OUT-1:0] re_out, im_out;
    logic sat_re, sat_im;
    logic unused_b_tlast;

    assign unused_b_tlast = &{1'b0, b_tlast};

    // Each stage may load when empty or when its successor frees it this cycle.
    assign s4_ready = !o_tvalid_q || o_tready;
    assign s3_ready = !s3_valid_q || s4_ready;
    assign s2_ready = !s2_valid_q || s3_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign accept   = a_tvalid && b_tvalid && s1_ready && reset;
    assign a_tready = accept;
    assign b_tready = accept;

    assign ar = `CMUL_FIELD_I(s1_a_q, WIDTH_IN);
    assign ai = `CMUL_FIELD_Q(s1_a_q, WIDTH_IN);
    assign br = `CMUL_FIELD_I(s1_b_q, WIDTH_IN);
    assign bi = `CMUL_FIELD_Q(s1_b_q, WIDTH_IN);

    cmul_round_sat #(.WIDTH_IN(SW), .WIDTH_OUT(WIDTH_OUT), .SHIFT(SHIFT), .ROUND(ROUND))
        u_sat_re (.din(s3_re_q), .dout(re_out), .sat(sat_re));
    cmul_round_sat #(.WIDTH_IN(SW), .WIDTH_OUT(WIDTH_OUT), .SHIFT(SHIFT), .ROUND(ROUND))
        u_sat_im (.din(s3_im_q), .dout(im_out), .sat(sat_im));

    always_comb begin
        s1_valid_d = s1_valid_q; s1_a_d = s1_a_q; s1_b_d = s1_b_q;
        s1_conj_d  = s1_conj_q;  s1_last_d = s1_last_q;
        s2_valid_d = s2_valid_q; s2_conj_d = s2_conj_q; s2_last_d = s2_last_q;
        s2_rr_d = s2_rr_q; s2_ii_d = s2_ii_q; s2_ir_d = s2_ir_q; s2_ri_d = s2_ri_q;
        s3_valid_d = s3_valid_q; s3_last_d = s3_last_q; s3_re_d = s3_re_q; s3_im_d = s3_im_q;
        o_tvalid_d = o_tvalid_q; o_tdata_d = o_tdata_q; o_tuser_d = o_tuser_q; o_tlast_d = o_tlast_q;

        if (s1_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d = a_tdata; s1_b_d = b_tdata; s1_conj_d = conj_b; s1_last_d = a_tlast;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rr_d = PW'(ar) * PW'(br);
                s2_ii_d = PW'(ai) * PW'(bi);
                s2_ir_d = PW'(ai) * PW'(br);
                s2_ri_d = PW'(ar) * PW'(bi);
                s2_conj_d = s1_conj_q; s2_last_d = s1_last_q;
            end
        end
        if (s3_ready) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_re_d = s2_conj_q ? SW'(s2_rr_q) + SW'(s2_ii_q) : SW'(s2_rr_q) - SW'(s2_ii_q);
                s3_im_d = s2_conj_q ? SW'(s2_ir_q) - SW'(s2_ri_q) : SW'(s2_ir_q) + SW'(s2_ri_q);
                s3_last_d = s2_last_q;
            end
        end
        if (s4_ready) begin
            o_tvalid_d = s3_valid_q;
            if (s3_valid_q) begin
                o_tdata_d = {re_out, im_out}; o_tuser_d = {sat_re, sat_im}; o_tlast_d = s3_last_q;
            end
        end
    end

    // A clear that coincides with a counted beat keeps that beat.
    always_comb begin
        sat_inc     = o_tvalid_q && o_tready && (o_tuser_q != 2'b00);
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = sat_inc ? CNT_WIDTH'(1) : '0;
        end else if (sat_inc && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0; s1_a_q <= '0; s1_b_q <= '0; s1_conj_q <= 1'b0; s1_last_q <= 1'b0;
            s2_valid_q <= 1'b0; s2_conj_q <= 1'b0; s2_last_q <= 1'b0;
            s2_rr_q <= '0; s2_ii_q <= '0; s2_ir_q <= '0; s2_ri_q <= '0;
            s3_valid_q <= 1'b0; s3_last_q <= 1'b0; s3_re_q <= '0; s3_im_q <= '0;
            o_tvalid_q <= 1'b0; o_tdata_q <= '0; o_tuser_q <= '0; o_tlast_q <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d;
            s1_conj_q <= s1_conj_d; s1_last_q <= s1_last_d;
            s2_valid_q <= s2_valid_d; s2_conj_q <= s2_conj_d; s2_last_q <= s2_last_d;
            s2_rr_q <= s2_rr_d; s2_ii_q <= s2_ii_d; s2_ir_q <= s2_ir_d; s2_ri_q <= s2_ri_d;
            s3_valid_q <= s3_valid_d; s3_last_q <= s3_last_d; s3_re_q <= s3_re_d; s3_im_q <= s3_im_d;
            o_tvalid_q <= o_tvalid_d; o_tdata_q <= o_tdata_d; o_tuser_q <= o_tuser_d;
            o_tlast_q <= o_tlast_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign o_tvalid  = o_tvalid_q;
    assign o_tdata   = o_tdata_q;
    assign o_tuser   = o_tuser_q;
    assign o_tlast   = o_tlast_q;
    assign sat_count = sat_count_q;
endmodule

// File: tb/tb_cmul_round_axis.sv
// Directed self-checking bench for cmul_round_axis: one round-half-up DUT and
// one truncating DUT share the same stimulus.
module tb_cmul_round_axis;
    logic        clk = 1'b0;
    logic        reset, a_tlast, a_tvalid, b_tlast, b_tvalid, conj_b, o_tready, sat_clear;
    logic [31:0] a_tdata, b_tdata;
    logic        a_tready, b_tready, o_tlast, o_tvalid;
    logic [31:0] o_tdata;
    logic [1:0]  o_tuser;
    logic [15:0] sat_count;
    logic        t_a_tready, t_b_tready, t_o_tlast, t_o_tvalid;
    logic [31:0] t_o_tdata;
    logic [1:0]  t_o_tuser;
    logic [15:0] t_sat_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cmul_round_axis dut (
        .clk(clk), .reset(reset),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b_tready),
        .conj_b(conj_b), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .sat_count(sat_count), .sat_clear(sat_clear)
    );

    cmul_round_axis #(.ROUND(0)) dut_trunc (
        .clk(clk), .reset(reset),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(t_a_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(t_b_tready),
        .conj_b(conj_b), .o_tdata(t_o_tdata), .o_tlast(t_o_tlast), .o_tuser(t_o_tuser),
        .o_tvalid(t_o_tvalid), .o_tready(o_tready), .sat_count(t_sat_count), .sat_clear(sat_clear)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Presents one beat, waits for it to be taken, then counts edges until the result shows.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic conj,
                                 output logic [31:0] data, output logic [1:0] user, output int lat);
        int guard;
        @(negedge clk);
        a_tdata = a; b_tdata = b; conj_b = conj; a_tlast = 1'b0;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        #1;
        guard = 0;
        while (!a_tready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        checkOutput("accept_ready", 64'(a_tready), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        #1;
        while (!o_tvalid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk); #1;
        end
        data = o_tdata;
        user = o_tuser;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  u;
        int          lat;
        logic [31:0] a_tab [8];
        logic [31:0] e_tab [8];
        logic [15:0] b_pat;
        int          tx, rx, cyc, inflight;
        logic        stalled_prev, exp_rdy, acc, pop, saw_drop, stale;
        logic [31:0] held;

        a_tab = '{32'h0800_1000, 32'h1000_1000, 32'h1800_1000, 32'h2000_1000,
                  32'h2800_1000, 32'h3000_1000, 32'h3800_1000, 32'h4000_1000};
        e_tab = '{32'h0400_0800, 32'h0800_0800, 32'h0C00_0800, 32'h1000_0800,
                  32'h1400_0800, 32'h1800_0800, 32'h1C00_0800, 32'h2000_0800};
        b_pat = 16'b1111_1101_1011_1101;

        // Hold reset with both valids high: nothing may be accepted and outputs stay clear.
        reset = 1'b0; a_tvalid = 1'b1; b_tvalid = 1'b1; a_tlast = 1'b0; b_tlast = 1'b0;
        conj_b = 1'b0; o_tready = 1'b1; sat_clear = 1'b0;
        a_tdata = 32'h4000_0000; b_tdata = 32'h4000_0000;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("rst_tdata", 64'(o_tdata), 64'd0);
        checkOutput("rst_tuser", 64'(o_tuser), 64'd0);
        checkOutput("rst_tlast", 64'(o_tlast), 64'd0);
        checkOutput("rst_count", 64'(sat_count), 64'd0);
        checkOutput("rst_a_tready", 64'(a_tready), 64'd0);
        checkOutput("rst_b_tready", 64'(b_tready), 64'd0);
        reset = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0;

        // Basic product and latency.
        applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b0, d, u, lat);
        checkOutput("basic_lat", 64'(lat), 64'd4);
        checkOutput("basic_data", 64'(d), 64'h2000_0000);
        checkOutput("basic_user", 64'(u), 64'd0);

        // Conjugate mode on pure-imaginary operands.
        applyStimulus(32'h0000_4000, 32'h0000_4000, 1'b0, d, u, lat);
        checkOutput("conj0_data", 64'(d), 64'hE000_0000);
        applyStimulus(32'h0000_4000, 32'h0000_4000, 1'b1, d, u, lat);
        checkOutput("conj1_data", 64'(d), 64'h2000_0000);

        // Most-negative operands saturate Q; then clear coincides with another saturating beat.
        applyStimulus(32'h8000_8000, 32'h8000_8000, 1'b0, d, u, lat);
        checkOutput("sat_data", 64'(d), 64'h0000_7FFF);
        checkOutput("sat_user", 64'(u), 64'd1);
        @(negedge clk); #1;
        checkOutput("sat_count1", 64'(sat_count), 64'd1);
        applyStimulus(32'h8000_8000, 32'h8000_8000, 1'b0, d, u, lat);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        #1;
        checkOutput("sat_clear_inc", 64'(sat_count), 64'd1);

        // Rounding versus truncation near zero.
        applyStimulus(32'h0001_0000, 32'h4000_0000, 1'b0, d, u, lat);
        checkOutput("rnd_pos_half_up", 64'(d), 64'h0001_0000);
        checkOutput("rnd_pos_trunc", 64'(t_o_tdata), 64'h0000_0000);
        applyStimulus(32'hFFFF_0000, 32'h4000_0000, 1'b0, d, u, lat);
        checkOutput("rnd_neg_half_up", 64'(d), 64'h0000_0000);
        checkOutput("rnd_neg_trunc", 64'(t_o_tdata), 64'hFFFF_0000);

        // Eight-beat packet with toggling b_tvalid and a five-cycle output stall.
        tx = 0; rx = 0; cyc = 0; inflight = 0;
        stalled_prev = 1'b0; saw_drop = 1'b0; held = '0;
        while (rx < 8 && cyc < 100) begin
            @(negedge clk);
            a_tvalid = (tx < 8);
            if (tx < 8) begin
                a_tdata = a_tab[tx];
                a_tlast = (tx == 7);
            end
            b_tdata  = 32'h4000_0000;
            conj_b   = 1'b0;
            b_tvalid = (cyc < 16) ? b_pat[cyc] : 1'b1;
            o_tready = !(cyc >= 3 && cyc <= 7);
            #1;
            exp_rdy = a_tvalid && b_tvalid && ((inflight < 4) || o_tready);
            checkOutput("bp_a_tready", 64'(a_tready), 64'(exp_rdy));
            if (a_tvalid && b_tvalid && !a_tready) saw_drop = 1'b1;
            if (stalled_prev) begin
                checkOutput("bp_hold_valid", 64'(o_tvalid), 64'd1);
                checkOutput("bp_hold_data", 64'(o_tdata), 64'(held));
            end
            pop = o_tvalid && o_tready;
            if (pop) begin
                checkOutput("bp_data", 64'(o_tdata), 64'(e_tab[rx]));
                checkOutput("bp_last", 64'(o_tlast), 64'(rx == 7));
                rx++;
            end
            stalled_prev = o_tvalid && !o_tready;
            held = o_tdata;
            acc = a_tvalid && b_tvalid && a_tready;
            if (acc) tx++;
            inflight = inflight + int'(acc) - int'(pop);
            cyc++;
        end
        checkOutput("bp_rx_count", 64'(rx), 64'd8);
        checkOutput("bp_ready_drop", 64'(saw_drop), 64'd1);

        // Reset with three beats in flight drops them all and clears the counter.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_tdata = a_tab[i]; b_tdata = 32'h4000_0000; a_tlast = 1'b0;
            conj_b = 1'b0; o_tready = 1'b1; a_tvalid = 1'b1; b_tvalid = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0; a_tvalid = 1'b0; b_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rm_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("rm_count", 64'(sat_count), 64'd0);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk); #1;
            if (o_tvalid) stale = 1'b1;
        end
        checkOutput("rm_no_stale", 64'(stale), 64'd0);
        applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b0, d, u, lat);
        checkOutput("rm_next_lat", 64'(lat), 64'd4);
        checkOutput("rm_next_data", 64'(d), 64'h2000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
